alu_sequencer: RTL and testbench

Sequencer and arbiter that shares the single combinational ALU between two requesters. It accepts operation requests over valid/ready handshakes and grants them round-robin. For each accepted operation it holds the ALU operands and opcode stable for a per-operation latency, then captures the Lower/Upper/Zero results. It returns them with a requester ID and error flag over a response handshake. It sits between the datapath control units and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU sequencer:
//   - opcode constants understood by the shared ALU
//   - sequencer state encoding (IDLE / EXEC / RESP)
//   - op_latency(): number of EXEC cycles an opcode needs
//   - op_legal():   whether the ALU implements an opcode
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_SWAP = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // EXEC cycles for an opcode; multiply and divide are multi-cycle in the ALU.
  function automatic int op_latency(input logic [3:0] op, input int mul_lat, input int div_lat);
    case (op)
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return 1;
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOV, OP_SWAP, OP_AND, OP_OR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter. When both requesters are valid the one that
//   was not granted most recently wins; a lone valid is always granted.
//   Ports:
//     clk      clock, rising edge
//     rst      asynchronous active-low reset (pointer -> requester 1)
//     valid    per-requester request (already qualified by the caller)
//     advance  a grant was taken this cycle; move the pointer
//     grant    one-hot (or zero) combinational grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q = 1 means requester 1 was granted most recently. Resetting it to 1
  // lets requester 0 win the first tie.
  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Shares one combinational ALU between two requesters. A request is granted
//   round-robin in IDLE, its opcode/operands are latched and driven to the ALU
//   for the opcode's latency (EXEC), then the ALU results are captured and
//   offered on the response handshake (RESP). Illegal opcodes and divide by
//   zero skip EXEC and respond immediately with rsp_err=1 and zero results.
//   Ports:
//     clk, rst                     clock / asynchronous active-low reset
//     reqN_valid/ready/op/a/b      request handshakes, N = 0,1
//     rsp_valid/ready              response handshake
//     rsp_id/lower/upper/zero/err  response payload
//     alu_op/data1/data2           to the ALU, held from latched registers
//     alu_lower/upper/zero         from the ALU
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 17,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_lower,
  output logic [DATA_W-1:0] rsp_upper,
  output logic [1:0]        rsp_zero,
  output logic              rsp_err,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_lower,
  input  logic [DATA_W-1:0] alu_upper,
  input  logic [1:0]        alu_zero
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // Counter holds latency-1, so values 0..MAX_LAT-1.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] lower_q, lower_d, upper_q, upper_d;
  logic [1:0]        zero_q, zero_d;
  logic              err_q, err_d;

  logic [1:0]        arb_valid, grant;
  logic              accept, sel_id, sel_ok;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [CNT_W-1:0]  lat_m1;

  // Requests are only visible to the arbiter in IDLE and out of reset, so
  // ready can never rise while busy or while reset is held.
  assign arb_valid = {req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && rst}};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel_id = grant[1];
  assign sel_op = sel_id ? req1_op : req0_op;
  assign sel_a  = sel_id ? req1_a  : req0_a;
  assign sel_b  = sel_id ? req1_b  : req0_b;
  assign sel_ok = op_legal(sel_op) && !((sel_op == OP_DIV) && (sel_b == '0));
  assign lat_m1 = CNT_W'(op_latency(sel_op, MUL_LAT, DIV_LAT) - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    lower_d = lower_q;
    upper_d = upper_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = sel_op;
          a_d  = sel_a;
          b_d  = sel_b;
          id_d = sel_id;
          if (sel_ok) begin
            state_d = ST_EXEC;
            cnt_d   = lat_m1;
          end else begin
            // Rejected op: answer straight away without using the ALU result.
            state_d = ST_RESP;
            lower_d = '0;
            upper_d = '0;
            zero_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          lower_d = alu_lower;
          upper_d = alu_upper;
          zero_d  = alu_zero;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      lower_q <= '0;
      upper_q <= '0;
      zero_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      lower_q <= lower_d;
      upper_q <= upper_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_lower = lower_q;
  assign rsp_upper = upper_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;
  assign alu_op    = op_q;
  assign alu_data1 = a_q;
  assign alu_data2 = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int DW   = 17;
  localparam int MULL = 2;
  localparam int DIVL = 4;

  localparam logic [3:0] T_ADD = 4'b0000, T_SUB = 4'b0001, T_MUL = 4'b0100, T_DIV = 4'b0101;
  localparam logic [3:0] T_MOV = 4'b0111, T_SWAP = 4'b1000, T_AND = 4'b1001, T_OR = 4'b1011;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_op = '0, req1_op = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
  logic [DW-1:0] rsp_lower, rsp_upper;
  logic [1:0]    rsp_zero;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_data1, alu_data2, alu_lower, alu_upper;
  logic [1:0]    alu_zero;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] legal_ops [8] = '{T_ADD, T_SUB, T_MUL, T_DIV, T_MOV, T_SWAP, T_AND, T_OR};

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(DW), .MUL_LAT(MULL), .DIV_LAT(DIVL)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lower(rsp_lower), .rsp_upper(rsp_upper), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_lower(alu_lower), .alu_upper(alu_upper), .alu_zero(alu_zero)
  );

  // Behavioural stand-in for the shared ALU. Ops that leave Upper alone
  // present a^b there, standing for whatever Upper currently shows.
  typedef struct packed {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [1:0]    z;
  } res_t;

  function automatic res_t alu_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t r;
    logic [2*DW-1:0] p;
    r.lo = '0;
    r.hi = a ^ b;
    case (op)
      T_ADD:  r.lo = a + b;
      T_SUB:  r.lo = a - b;
      T_MUL:  begin
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        r.lo = p[DW-1:0];
        r.hi = p[2*DW-1:DW];
      end
      T_DIV:  begin
        if (b != '0) begin r.lo = a / b; r.hi = a % b; end
        else begin r.lo = '0; r.hi = '0; end
      end
      T_MOV:  r.lo = a;
      T_SWAP: begin r.lo = b; r.hi = a; end
      T_AND:  r.lo = a & b;
      T_OR:   r.lo = a | b;
      default: r.lo = '0;
    endcase
    r.z = {(r.hi == '0), (r.lo == '0)};
    return r;
  endfunction

  res_t alu_res;
  assign alu_res   = alu_ref(alu_op, alu_data1, alu_data2);
  assign alu_lower = alu_res.lo;
  assign alu_upper = alu_res.hi;
  assign alu_zero  = alu_res.z;

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {T_ADD, T_SUB, T_MUL, T_DIV, T_MOV, T_SWAP, T_AND, T_OR};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == T_MUL) return MULL;
    if (op == T_DIV) return DIVL;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Transaction timeline: an op accepted during cycle c responds from cycle
  // c+1 (rejected) or c+1+latency (executed) until the response handshake.
  int         cyc = 0;
  int         resp_at = 0;
  int         last_g = 1;
  bit         busy = 1'b0;
  logic [3:0]    m_op = '0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic          m_id = 1'b0, m_err = 1'b0;
  res_t          m_res = '0;

  always @(negedge clk) begin
    bit g0, g1, resp;
    if (!rst) begin
      chk("rst_ready0", 64'(req0_ready), 64'd0);
      chk("rst_ready1", 64'(req1_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_alu_data1", 64'(alu_data1), 64'd0);
      chk("rst_alu_data2", 64'(alu_data2), 64'd0);
      chk("rst_rsp_lower", 64'(rsp_lower), 64'd0);
      chk("rst_rsp_upper", 64'(rsp_upper), 64'd0);
      chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      busy = 1'b0; last_g = 1; m_op = '0; m_a = '0; m_b = '0; cyc = 0;
    end else begin
      g0 = 1'b0; g1 = 1'b0;
      if (!busy) begin
        if (req0_valid && req1_valid) begin
          if (last_g == 1) g0 = 1'b1; else g1 = 1'b1;
        end else if (req0_valid) g0 = 1'b1;
        else if (req1_valid) g1 = 1'b1;
      end
      resp = busy && (cyc >= resp_at);
      chk("ready0", 64'(req0_ready), 64'(g0));
      chk("ready1", 64'(req1_ready), 64'(g1));
      chk("rsp_valid", 64'(rsp_valid), 64'(resp));
      if (resp) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_lower", 64'(rsp_lower), 64'(m_res.lo));
        chk("rsp_upper", 64'(rsp_upper), 64'(m_res.hi));
        chk("rsp_zero", 64'(rsp_zero), 64'(m_res.z));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
      end
      chk("alu_op", 64'(alu_op), 64'(m_op));
      chk("alu_data1", 64'(alu_data1), 64'(m_a));
      chk("alu_data2", 64'(alu_data2), 64'(m_b));
      if (g0 || g1) begin
        m_id = g1;
        m_op = g1 ? req1_op : req0_op;
        m_a  = g1 ? req1_a  : req0_a;
        m_b  = g1 ? req1_b  : req0_b;
        last_g = g1 ? 1 : 0;
        busy = 1'b1;
        if (!is_legal(m_op) || (m_op == T_DIV && m_b == '0)) begin
          m_err = 1'b1; m_res = '0; resp_at = cyc + 1;
        end else begin
          m_err = 1'b0; m_res = alu_ref(m_op, m_a, m_b); resp_at = cyc + 1 + lat_of(m_op);
        end
      end else if (resp && rsp_ready) begin
        busy = 1'b0;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload(output logic [3:0] op, output logic [DW-1:0] a, output logic [DW-1:0] b);
    if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
    else op = legal_ops[$urandom_range(0, 7)];
    a = DW'($urandom);
    case ($urandom_range(0, 5))
      0:       b = '0;
      1:       b = DW'($urandom_range(1, 15));
      default: b = DW'($urandom);
    endcase
  endtask

  initial begin
    int ng;
    bit acc0, acc1;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // Alternating grants under a continuous tie, starting with req0.
    req0_valid = 1; req1_valid = 1; req0_op = T_SUB; req1_op = T_SUB;
    req0_a = 10; req0_b = 3; req1_a = 20; req1_b = 5; rsp_ready = 1;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      @(negedge clk);
      chk("alt_both_ready", 64'(req0_ready & req1_ready), 64'd0);
      if (req0_ready || req1_ready) begin
        chk("alt_grant_id", 64'(req1_ready), 64'(ng % 2));
        ng++;
      end
      tick();
    end
    chk("alt_grant_count", 64'(ng), 64'd4);
    req0_valid = 0; req1_valid = 0;
    repeat (3) tick();

    // ADD 5+3 from req0.
    req0_valid = 1; req0_op = T_ADD; req0_a = 5; req0_b = 3;
    @(negedge clk); chk("add_ready0", 64'(req0_ready), 64'd1);
    tick(); req0_valid = 0;
    @(negedge clk);
    chk("add_exec_op", 64'(alu_op), 64'd0);
    chk("add_exec_d1", 64'(alu_data1), 64'd5);
    chk("add_exec_norsp", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_lower", 64'(rsp_lower), 64'd8);
    chk("add_id", 64'(rsp_id), 64'd0);
    chk("add_err", 64'(rsp_err), 64'd0);
    tick();

    // MUL 6*7 from req1, two EXEC cycles.
    req1_valid = 1; req1_op = T_MUL; req1_a = 6; req1_b = 7;
    @(negedge clk); chk("mul_ready1", 64'(req1_ready), 64'd1);
    tick(); req1_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mul_exec_op", 64'(alu_op), 64'h4);
      chk("mul_exec_d1", 64'(alu_data1), 64'd6);
      chk("mul_exec_d2", 64'(alu_data2), 64'd7);
      chk("mul_exec_norsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("mul_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("mul_lower", 64'(rsp_lower), 64'd42);
    chk("mul_id", 64'(rsp_id), 64'd1);
    tick();

    // Divide by zero, then illegal opcode 0010: immediate error response.
    req0_valid = 1; req0_op = T_DIV; req0_a = 9; req0_b = 0;
    @(negedge clk); chk("div0_ready0", 64'(req0_ready), 64'd1);
    tick(); req0_valid = 0;
    @(negedge clk);
    chk("div0_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("div0_err", 64'(rsp_err), 64'd1);
    chk("div0_results", 64'({rsp_lower, rsp_upper, rsp_zero}), 64'd0);
    tick();
    req1_valid = 1; req1_op = 4'b0010; req1_a = 9; req1_b = 3;
    @(negedge clk); chk("ill_ready1", 64'(req1_ready), 64'd1);
    tick(); req1_valid = 0;
    @(negedge clk);
    chk("ill_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("ill_err", 64'(rsp_err), 64'd1);
    chk("ill_results", 64'({rsp_lower, rsp_upper, rsp_zero}), 64'd0);
    tick();

    // SWAP with a stalled consumer; a competing request must wait.
    rsp_ready = 0;
    req1_valid = 1; req1_op = T_SWAP; req1_a = 1; req1_b = 2;
    @(negedge clk); chk("swap_ready1", 64'(req1_ready), 64'd1);
    tick(); req1_valid = 0;
    @(negedge clk); chk("swap_exec_norsp", 64'(rsp_valid), 64'd0);
    tick();
    req0_valid = 1; req0_op = T_ADD; req0_a = 3; req0_b = 4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("swap_hold_valid", 64'(rsp_valid), 64'd1);
      chk("swap_hold_lower", 64'(rsp_lower), 64'd2);
      chk("swap_hold_upper", 64'(rsp_upper), 64'd1);
      chk("swap_no_grant", 64'(req0_ready), 64'd0);
      tick();
      if (i == 4) rsp_ready = 1;
    end
    @(negedge clk);
    chk("swap_after_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("swap_next_grant", 64'(req0_ready), 64'd1);
    tick(); req0_valid = 0;
    repeat (3) tick();

    // Randomised traffic; pending requests hold until granted.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        rand_payload(req0_op, req0_a, req0_b);
      end else if ($urandom_range(0, 3) == 0) begin
        rand_payload(req0_op, req0_a, req0_b);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        rand_payload(req1_op, req1_a, req1_b);
      end else if ($urandom_range(0, 3) == 0) begin
        rand_payload(req1_op, req1_a, req1_b);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (8) tick();

    // Reset in the middle of a divide.
    req0_valid = 1; req0_op = T_DIV; req0_a = 20; req0_b = 5;
    @(negedge clk); chk("rdiv_ready0", 64'(req0_ready), 64'd1);
    tick(); req0_valid = 0;
    @(negedge clk);
    tick();
    req0_valid = 1; req1_valid = 1; req0_op = T_ADD; req1_op = T_OR;
    rst = 1'b0;
    #1;
    chk("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_async_alu_op", 64'(alu_op), 64'd0);
    chk("rst_async_alu_d1", 64'(alu_data1), 64'd0);
    chk("rst_async_ready", 64'({req1_ready, req0_ready}), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_r0", 64'(req0_ready), 64'd1);
    chk("post_rst_tie_r1", 64'(req1_ready), 64'd0);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    tick(); req0_valid = 0; req1_valid = 0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
